// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - LSU state encoding and RISC-V Funct3 access codes
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane select and sign/zero extension
// Sub-word extraction only when LSU_SUBWORD_EN is defined; otherwise aligned words only.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

`ifdef LSU_SUBWORD_EN
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      LB:      data = {{24{byte_v[7]}}, byte_v};
      LBU:     data = {24'h0, byte_v};
      LH:      data = {{16{half_v[15]}}, half_v};
      LHU:     data = {16'h0, half_v};
      default: data = word;
    endcase
  end
`else
  always_comb begin
    data = (funct3 == LW && lane == 2'b00) ? word : 32'h0;
  end
`endif

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit for a word-addressed synchronous memory
// Sub-word loads/stores (read-modify-write) enabled by LSU_SUBWORD_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEMORY_SIZE = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        Request,
  input  logic        WriteOp,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ByteAddress,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemReadData,
  output logic [31:0] MemAddress,
  output logic        MemWriteEnable,
  output logic [31:0] MemWriteData,
  output logic [31:0] LoadData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault
);

  state_t      state;
  logic        write_op_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        fault_now;
  logic [31:0] aligned;
  logic [31:0] merged;

  always_comb begin
    fault_now = 1'b0;
`ifdef LSU_SUBWORD_EN
    case (Funct3)
      LB:      fault_now = 1'b0;
      LBU:     fault_now = WriteOp;
      LH:      fault_now = ByteAddress[0];
      LHU:     fault_now = WriteOp | ByteAddress[0];
      LW:      fault_now = |ByteAddress[1:0];
      default: fault_now = 1'b1;
    endcase
`else
    fault_now = (Funct3 != LW) || (|ByteAddress[1:0]);
`endif
    if (ByteAddress[31:2] >= 30'(MEMORY_SIZE)) fault_now = 1'b1;
  end

`ifdef LSU_SUBWORD_EN
  logic [15:0] store_lane_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) store_lane_q <= '0;
    else if (state == IDLE && Request) store_lane_q <= StoreData[15:0];
  end

  // Insert the store lane into the word read back during CAPTURE.
  always_comb begin
    merged = MemReadData;
    if (funct3_q == SB) merged[{lane_q, 3'b000} +: 8] = store_lane_q[7:0];
    else merged[{lane_q[1], 4'b0000} +: 16] = store_lane_q;
  end
`else
  always_comb begin
    merged = MemReadData;
  end
`endif

  lsu_load_align u_align (
    .word   (MemReadData),
    .funct3 (funct3_q),
    .lane   (lane_q),
    .data   (aligned)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      write_op_q     <= 1'b0;
      funct3_q       <= '0;
      lane_q         <= '0;
      MemAddress     <= '0;
      MemWriteEnable <= 1'b0;
      MemWriteData   <= '0;
      LoadData       <= '0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Fault          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Request) begin
          write_op_q <= WriteOp;
          funct3_q   <= Funct3;
          lane_q     <= ByteAddress[1:0];
          Busy       <= 1'b1;
          if (fault_now) begin
            state <= DONE;
            Done  <= 1'b1;
            Fault <= 1'b1;
          end else if (WriteOp && Funct3 == SW) begin
            state          <= WRITE;
            MemAddress     <= {2'b00, ByteAddress[31:2]};
            MemWriteData   <= StoreData;
            MemWriteEnable <= 1'b1;
          end else begin
            state      <= READ;
            MemAddress <= {2'b00, ByteAddress[31:2]};
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          if (write_op_q) begin
            state          <= WRITE;
            MemWriteData   <= merged;
            MemWriteEnable <= 1'b1;
          end else begin
            state    <= DONE;
            LoadData <= aligned;
            Done     <= 1'b1;
          end
        end
        WRITE: begin
          state          <= DONE;
          MemWriteEnable <= 1'b0;
          Done           <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          MemAddress     <= '0;
          MemWriteEnable <= 1'b0;
          Busy           <= 1'b0;
          Done           <= 1'b0;
          Fault          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// Expected values follow LSU_SUBWORD_EN when defined for the build.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        Request;
  logic        WriteOp;
  logic [2:0]  Funct3;
  logic [31:0] ByteAddress;
  logic [31:0] StoreData;
  logic [31:0] MemReadData;
  logic [31:0] MemAddress;
  logic        MemWriteEnable;
  logic [31:0] MemWriteData;
  logic [31:0] LoadData;
  logic        Busy;
  logic        Done;
  logic        Fault;

  logic [31:0] mem [0:63];
  int          we_total = 0;
  int          done_total = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load;
  logic [31:0] word4;

  load_store_unit #(.MEMORY_SIZE(64)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .Request        (Request),
    .WriteOp        (WriteOp),
    .Funct3         (Funct3),
    .ByteAddress    (ByteAddress),
    .StoreData      (StoreData),
    .MemReadData    (MemReadData),
    .MemAddress     (MemAddress),
    .MemWriteEnable (MemWriteEnable),
    .MemWriteData   (MemWriteData),
    .LoadData       (LoadData),
    .Busy           (Busy),
    .Done           (Done),
    .Fault          (Fault)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MemWriteEnable) begin
      mem[MemAddress[5:0]] <= MemWriteData;
      we_total <= we_total + 1;
    end
    MemReadData <= mem[MemAddress[5:0]];
  end

  always @(negedge CLK) if (Done) done_total <= done_total + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int exp_lat, input logic exp_flt, input logic [31:0] exp_addr,
                        input int exp_we, input logic [31:0] exp_load);
    int          lat;
    int          we0;
    logic [31:0] addr_seen;
    we0 = we_total;
    Request = 1'b1; WriteOp = wr; Funct3 = f3; ByteAddress = addr; StoreData = sd;
    @(posedge CLK); #1;
    Request = 1'b0;
    addr_seen = MemAddress;
    lat = 0;
    while (!Done && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " done"}, {31'b0, Done}, 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " fault"}, {31'b0, Fault}, {31'b0, exp_flt});
    check({tag, " mem_address"}, addr_seen, exp_addr);
    check({tag, " load_data"}, LoadData, exp_load);
    @(posedge CLK); #1;
    check({tag, " we_cycles"}, we_total - we0, exp_we);
    check({tag, " idle"}, {29'b0, Busy, Done, Fault}, 32'd0);
  endtask

  initial begin
    int we0;
    int d0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    RESET_N = 1'b0; Request = 1'b0; WriteOp = 1'b0; Funct3 = 3'b0;
    ByteAddress = 32'h0; StoreData = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset ctrl", {28'b0, Busy, Done, Fault, MemWriteEnable}, 32'd0);
    check("reset mem_address", MemAddress, 32'd0);
    check("reset load_data", LoadData, 32'd0);
    check("reset write_data", MemWriteData, 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    access("sw 0x10", 1'b1, SW, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'd4, 1, 32'h0);
    check("sw 0x10 word", mem[4], 32'hDEADBEEF);
    access("lw 0x10", 1'b0, LW, 32'h10, 32'h0, 2, 1'b0, 32'd4, 0, 32'hDEADBEEF);
    last_load = 32'hDEADBEEF;

`ifdef LSU_SUBWORD_EN
    access("lb 0x13", 1'b0, LB, 32'h13, 32'h0, 2, 1'b0, 32'd4, 0, 32'hFFFFFFDE);
    access("lbu 0x13", 1'b0, LBU, 32'h13, 32'h0, 2, 1'b0, 32'd4, 0, 32'h000000DE);
    access("lh 0x12", 1'b0, LH, 32'h12, 32'h0, 2, 1'b0, 32'd4, 0, 32'hFFFFDEAD);
    access("lhu 0x10", 1'b0, LHU, 32'h10, 32'h0, 2, 1'b0, 32'd4, 0, 32'h0000BEEF);
    access("sb 0x12", 1'b1, SB, 32'h12, 32'h123456AA, 3, 1'b0, 32'd4, 1, 32'h0000BEEF);
    check("sb 0x12 word", mem[4], 32'hDEAABEEF);
    access("lw merged", 1'b0, LW, 32'h10, 32'h0, 2, 1'b0, 32'd4, 0, 32'hDEAABEEF);
    last_load = 32'hDEAABEEF;
    word4 = 32'hDEAABEEF;
`else
    access("lb 0x10 off", 1'b0, LB, 32'h10, 32'h0, 0, 1'b1, 32'd0, 0, last_load);
    access("sb 0x12 off", 1'b1, SB, 32'h12, 32'h000000AA, 0, 1'b1, 32'd0, 0, last_load);
    check("sb 0x12 off word", mem[4], 32'hDEADBEEF);
    word4 = 32'hDEADBEEF;
`endif

    access("sw top", 1'b1, SW, 32'hFC, 32'h12345678, 1, 1'b0, 32'd63, 1, last_load);
    access("lw top", 1'b0, LW, 32'hFC, 32'h0, 2, 1'b0, 32'd63, 0, 32'h12345678);
    last_load = 32'h12345678;

    access("lw 0x12", 1'b0, LW, 32'h12, 32'h0, 0, 1'b1, 32'd0, 0, last_load);
    access("sh 0x11", 1'b1, SH, 32'h11, 32'h5555, 0, 1'b1, 32'd0, 0, last_load);
    access("lw 0x100", 1'b0, LW, 32'h100, 32'h0, 0, 1'b1, 32'd0, 0, last_load);
    access("sw 0x100", 1'b1, SW, 32'h100, 32'h1, 0, 1'b1, 32'd0, 0, last_load);
    access("load f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b1, 32'd0, 0, last_load);
    access("store f3=100", 1'b1, 3'b100, 32'h10, 32'h1, 0, 1'b1, 32'd0, 0, last_load);
    check("fault words kept", mem[4], word4);

    // Request held high from IDLE through DONE: exactly one completion.
    d0 = done_total;
    Request = 1'b1; WriteOp = 1'b0; Funct3 = LW; ByteAddress = 32'h10;
    repeat (4) @(posedge CLK);
    #1 Request = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("busy ignore done_count", done_total - d0, 32'd1);
    check("busy ignore load_data", LoadData, word4);

    we0 = we_total; d0 = done_total;
`ifdef LSU_SUBWORD_EN
    Request = 1'b1; WriteOp = 1'b1; Funct3 = SH; ByteAddress = 32'h10; StoreData = 32'h5555;
`else
    Request = 1'b1; WriteOp = 1'b0; Funct3 = LW; ByteAddress = 32'h10; StoreData = 32'h0;
`endif
    @(posedge CLK); #1 Request = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    check("abort ctrl", {28'b0, Busy, Done, Fault, MemWriteEnable}, 32'd0);
    check("abort mem_address", MemAddress, 32'd0);
    check("abort load_data", LoadData, 32'd0);
    check("abort write_data", MemWriteData, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("abort we_cycles", we_total - we0, 32'd0);
    check("abort done_count", done_total - d0, 32'd0);
    check("abort word kept", mem[4], word4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
